ro_pair_sequencer: RTL and testbench
====================================

# ro_pair_sequencer

Drives the RO selection side of the delay-based PUF: for each 8-bit challenge it enables one ring oscillator at a time and steers the 16:1 RO multiplexer select. It then counts rising edges of the multiplexed RO output over a fixed window for each of the two challenged oscillators and produces one response bit from the comparison. It sits between the challenge source and the RO array/multiplexer; its `sel` output feeds the mux select, and its `ro_in` input is the mux output.

## Interface
- `WINDOW_CYCLES`, 1024: number of clk cycles per oscillator count window (≥1).
- `SETTLE_CYCLES`, 4: cycles after switching select/enable before counting starts (≥3, covers synchronizer latency).
- `CNT_W`, 16: edge-counter width.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request measurement; sampled only in IDLE.
- `challenge` in 8: [7:4] = oscillator index A, [3:0] = oscillator index B.
- `ro_in` in 1: multiplexed RO output, asynchronous to clk.
- `sel` out 4: RO mux select.
- `ro_en` out 16: one-hot RO enable (all zero when not measuring).
- `busy` out 1: high from the cycle after start is accepted until done.
- `done` out 1: one-cycle pulse; response/counts valid from this cycle.
- `response` out 1: 1 iff count_a > count_b.
- `count_a`, `count_b` out CNT_W: edge counts for A and B, held until the next accepted start.

## Operation
- `ro_in` passes through a 2-flop synchronizer and a rising-edge detector (third flop). Each detected edge is one count.
- States: IDLE → SETTLE_A → COUNT_A → SETTLE_B → COUNT_B → COMPARE → IDLE.
- **IDLE:** `ro_en`=0, `sel` holds its last value, `busy`=0. When `start`=1, latch `challenge` and go to SETTLE_A.
- **SETTLE_A:** `sel`=A, `ro_en`=1<<A. Lasts SETTLE_CYCLES, then clear the edge counter and enter COUNT_A.
- **COUNT_A:** lasts WINDOW_CYCLES. Count edge-detect pulses; the counter saturates at 2^CNT_W−1 with no wrap. At exit, store the result to `count_a`.
- **SETTLE_B / COUNT_B:** identical to the A states with index B. The B result is stored to `count_b`.
- **COMPARE:** 1 cycle. `response` = (count_a > count_b), an unsigned compare. `done`=1 and `ro_en`=0.
- A==B is legal. The same RO is measured twice; an equal result gives `response`=0.
- `start` while busy is ignored; there is no queuing. `challenge` changes while busy have no effect.
- Reset (any state, asynchronous): state=IDLE, and all outputs are 0 (`sel`, `ro_en`, `busy`, `done`, `response`, `count_a`, `count_b`). Synchronizer flops and counters are cleared. No `done` is generated for an aborted measurement.
- Edges faster than clk/2 alias. Upstream RO frequency must be below clk/2; this block does not check it.

## Timing
- `start` is sampled high at edge 0. SETTLE_A begins at edge 1, so `sel` and `ro_en` are valid after edge 1.
- COUNT_A spans edges 1+S to S+W, where S=SETTLE_CYCLES and W=WINDOW_CYCLES.
- COUNT_B ends at edge 2(S+W). COMPARE occupies the next cycle.
- `done` is high for exactly one cycle, starting at edge 2(S+W)+1. With defaults, that is edge 2057.
- The earliest next `start` is sampled at edge 2(S+W)+2.
- `busy` is high from edge 1 through the `done` cycle inclusive.
- `ro_en` is never multi-hot. Switching A→B changes `ro_en` in a single edge, with no overlap.

## Test plan
- **Reset:** assert `rst` mid-cycle with random inputs → all outputs 0 immediately (asynchronous); they remain 0 after release until `start`.
- **Basic compare:** challenge=0x3A; RO3 model toggles `ro_in` every 4 clk, RO10 every 5 clk; defaults → `sel`=3 with `ro_en`=0x0008, then `sel`=10 with `ro_en`=0x0400. Expect `count_a`=128±1, `count_b`=102±1, `response`=1, and the `done` pulse at edge 2057.
- **Swapped challenge:** challenge=0xA3 with the same models → `count_a`≈102, `count_b`≈128, `response`=0.
- **A==B:** challenge=0x55 with RO5 toggling every 4 clk → `count_a`=`count_b`=128, `response`=0.
- **Busy / abort:**
  - Pulse `start` with challenge=0x12 during COUNT_A → ignored; the original challenge completes.
  - Assert `rst` during COUNT_B → `ro_en`=0, `busy`=0, and no `done` follows.
- **Saturation:** CNT_W=4, WINDOW_CYCLES=64, RO toggling every 2 clk → `count_a`=15 (no wrap); `response` is computed on the saturated values.

Source files
------------

// File: rtl/ro_pair_sequencer.sv
// RO pair sequencer for the delay PUF: enables and selects the two challenged
// oscillators in turn, counts synchronized RO edges per window, and compares the counts.
module ro_pair_sequencer #(
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       challenge,
    input  logic             ro_in,
    output logic [3:0]       sel,
    output logic [15:0]      ro_en,
    output logic             busy,
    output logic             done,
    output logic             response,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
);

    localparam int unsigned TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE_A,
        S_COUNT_A,
        S_SETTLE_B,
        S_COUNT_B,
        S_COMPARE
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         chal_q, chal_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         sync_q, sync_d;
    logic [3:0]         sel_q, sel_d;
    logic [15:0]        ro_en_q, ro_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               resp_q, resp_d;
    logic [CNT_W-1:0]   count_a_q, count_a_d;
    logic [CNT_W-1:0]   count_b_q, count_b_d;

    logic [3:0]         idx_a_c, idx_b_c;
    logic               edge_c;

    assign idx_a_c = chal_q[7:4];
    assign idx_b_c = chal_q[3:0];
    // sync_q[1] is the synchronized RO level; sync_q[2] is its one-cycle-old copy
    assign edge_c  = sync_q[1] & ~sync_q[2];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_SETTLE_A;
            S_SETTLE_A: if (tmr_q == SETTLE_LAST) state_d = S_COUNT_A;
            S_COUNT_A:  if (tmr_q == WINDOW_LAST) state_d = S_SETTLE_B;
            S_SETTLE_B: if (tmr_q == SETTLE_LAST) state_d = S_COUNT_B;
            S_COUNT_B:  if (tmr_q == WINDOW_LAST) state_d = S_COMPARE;
            S_COMPARE:  state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath: challenge latch, phase timer, saturating edge counter, synchronizer
    always_comb begin
        chal_d = chal_q;
        tmr_d  = '0;
        cnt_d  = '0;
        sync_d = {sync_q[1:0], ro_in};

        if (state_q == S_IDLE && start) begin
            chal_d = challenge;
        end

        if (state_q != S_IDLE && state_d == state_q) begin
            tmr_d = tmr_q + TMR_W'(1);
        end

        // Settle phases hold the counter at zero so each window starts clean
        if (state_q == S_COUNT_A || state_q == S_COUNT_B) begin
            cnt_d = cnt_q;
            if (edge_c && cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output logic (registered outputs, one cycle behind the state register)
    always_comb begin
        sel_d     = sel_q;
        ro_en_d   = '0;
        busy_d    = (state_q != S_IDLE);
        done_d    = (state_q == S_COMPARE);
        resp_d    = resp_q;
        count_a_d = count_a_q;
        count_b_d = count_b_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    resp_d    = 1'b0;
                    count_a_d = '0;
                    count_b_d = '0;
                end
            end
            S_SETTLE_A: begin
                sel_d   = idx_a_c;
                ro_en_d = 16'(1) << idx_a_c;
            end
            S_COUNT_A: begin
                sel_d   = idx_a_c;
                ro_en_d = 16'(1) << idx_a_c;
                if (tmr_q == WINDOW_LAST) count_a_d = cnt_d;
            end
            S_SETTLE_B: begin
                sel_d   = idx_b_c;
                ro_en_d = 16'(1) << idx_b_c;
            end
            S_COUNT_B: begin
                sel_d   = idx_b_c;
                ro_en_d = 16'(1) << idx_b_c;
                if (tmr_q == WINDOW_LAST) count_b_d = cnt_d;
            end
            S_COMPARE: begin
                resp_d = (count_a_q > count_b_q);
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chal_q    <= '0;
            tmr_q     <= '0;
            cnt_q     <= '0;
            sync_q    <= '0;
            sel_q     <= '0;
            ro_en_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= 1'b0;
            count_a_q <= '0;
            count_b_q <= '0;
        end else begin
            chal_q    <= chal_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            sync_q    <= sync_d;
            sel_q     <= sel_d;
            ro_en_q   <= ro_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
            count_a_q <= count_a_d;
            count_b_q <= count_b_d;
        end
    end

    assign sel      = sel_q;
    assign ro_en    = ro_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign response = resp_q;
    assign count_a  = count_a_q;
    assign count_b  = count_b_q;

endmodule

// File: tb/tb_ro_pair_sequencer.sv
// Directed bench for ro_pair_sequencer: default-size instance plus a small
// saturating instance, each driven by a simple RO model keyed off the mux select.
module tb_ro_pair_sequencer;

    localparam int S  = 4;
    localparam int W  = 1024;
    localparam int SS = 4;
    localparam int WS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  challenge = 8'h00;
    logic        ro_in = 1'b0;
    logic [3:0]  sel;
    logic [15:0] ro_en;
    logic        busy, done, response;
    logic [15:0] count_a, count_b;

    logic        start_s = 1'b0;
    logic [7:0]  challenge_s = 8'h00;
    logic        ro_s = 1'b0;
    logic [3:0]  sel_s;
    logic [15:0] ro_en_s;
    logic        busy_s, done_s, response_s;
    logic [3:0]  count_a_s, count_b_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ro_pair_sequencer #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge), .ro_in(ro_in),
        .sel(sel), .ro_en(ro_en), .busy(busy), .done(done), .response(response),
        .count_a(count_a), .count_b(count_b)
    );

    ro_pair_sequencer #(.WINDOW_CYCLES(WS), .SETTLE_CYCLES(SS), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start_s), .challenge(challenge_s), .ro_in(ro_s),
        .sel(sel_s), .ro_en(ro_en_s), .busy(busy_s), .done(done_s), .response(response_s),
        .count_a(count_a_s), .count_b(count_b_s)
    );

    // RO models: half-period in clk cycles for whichever oscillator is selected
    function automatic int half_main(input logic [3:0] s);
        case (s)
            4'd3:    return 4;
            4'd5:    return 4;
            4'd10:   return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int half_sat(input logic [3:0] s);
        case (s)
            4'd1:    return 2;
            4'd2:    return 8;
            default: return 0;
        endcase
    endfunction

    int ph_m = 0;
    int ph_s = 0;
    always @(negedge clk) begin
        ph_m = ph_m + 1;
        if (half_main(sel) != 0 && ph_m >= half_main(sel)) begin
            ro_in = ~ro_in;
            ph_m  = 0;
        end
        ph_s = ph_s + 1;
        if (half_sat(sel_s) != 0 && ph_s >= half_sat(sel_s)) begin
            ro_s = ~ro_s;
            ph_s = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},   32'(sel), 32'd0);
        check({tag, "_ro_en"}, 32'(ro_en), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_resp"},  32'(response), 32'd0);
        check({tag, "_cnt_a"}, 32'(count_a), 32'd0);
        check({tag, "_cnt_b"}, 32'(count_b), 32'd0);
    endtask

    // One full measurement on the default instance; optionally pokes start mid COUNT_A
    task automatic measure(input logic [7:0] chal, input bit poke);
        int k;
        bit seen;
        logic [3:0] a, b;
        a = chal[7:4];
        b = chal[3:0];
        @(negedge clk);
        start = 1'b1;
        challenge = chal;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        challenge = 8'($urandom);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 3000) begin
            @(posedge clk);
            k++;
            #1;
            if (k == 1) begin
                check("busy_on", 32'(busy), 32'd1);
                check("sel_a", 32'(sel), 32'(a));
                check("en_a", 32'(ro_en), 32'(16'(1) << a));
            end
            if (k == S + W) check("sel_a_last", 32'(sel), 32'(a));
            if (k == S + W + 1) begin
                check("sel_b", 32'(sel), 32'(b));
                check("en_b", 32'(ro_en), 32'(16'(1) << b));
            end
            if (poke && k == S + 100) begin
                start = 1'b1;
                challenge = 8'h12;
                @(negedge clk);
                start = 1'b0;
            end
            if (poke && k == S + 102) check("poke_en_a", 32'(ro_en), 32'(16'(1) << a));
            if (done) seen = 1'b1;
        end
        check("done_edge", 32'(k), 32'(2 * (S + W) + 1));
        check("busy_at_done", 32'(busy), 32'd1);
        check("en_at_done", 32'(ro_en), 32'd0);
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);
        check("busy_off", 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        bit seen;
        bit in_rng;

        // Reset and quiet period
        challenge = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("rst");
        repeat (5) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_en", 32'(ro_en), 32'd0);

        // Basic compare: RO3 period 8, RO10 period 10
        measure(8'h3A, 1'b0);
        check("basic_cnt_a", 32'(count_a), 32'd128);
        in_rng = (count_b >= 16'd101 && count_b <= 16'd103);
        check("basic_cnt_b_rng", 32'(in_rng), 32'd1);
        check("basic_resp", 32'(response), 32'd1);

        // Swapped challenge
        measure(8'hA3, 1'b0);
        in_rng = (count_a >= 16'd101 && count_a <= 16'd103);
        check("swap_cnt_a_rng", 32'(in_rng), 32'd1);
        check("swap_cnt_b", 32'(count_b), 32'd128);
        check("swap_resp", 32'(response), 32'd0);

        // Same oscillator twice
        measure(8'h55, 1'b0);
        check("eq_cnt_a", 32'(count_a), 32'd128);
        check("eq_cnt_b", 32'(count_b), 32'd128);
        check("eq_resp", 32'(response), 32'd0);

        // Start while busy is ignored
        measure(8'h3A, 1'b1);
        check("poke_cnt_a", 32'(count_a), 32'd128);
        check("poke_resp", 32'(response), 32'd1);

        // Abort during COUNT_B with an asynchronous mid-cycle reset
        @(negedge clk);
        start = 1'b1;
        challenge = 8'h3A;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2 * S + W + 100) @(posedge clk);
        #1;
        check("pre_abort_sel", 32'(sel), 32'd10);
        #2;
        rst = 1'b1;
        challenge = 8'($urandom);
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2200; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);

        // Saturating instance: RO1 period 4 (16 edges -> 15), RO2 period 16 (4 edges)
        @(negedge clk);
        start_s = 1'b1;
        challenge_s = 8'h12;
        @(posedge clk);
        @(negedge clk);
        start_s = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 500) begin
            @(posedge clk);
            k++;
            #1;
            if (done_s) seen = 1'b1;
        end
        check("sat_done_edge", 32'(k), 32'(2 * (SS + WS) + 1));
        check("sat_cnt_a", 32'(count_a_s), 32'd15);
        check("sat_cnt_b", 32'(count_b_s), 32'd4);
        check("sat_resp", 32'(response_s), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
